// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the round-robin FIFO write-port arbiter:
//   FSM state encoding, default parameter values and the width helpers
//   used to size the tag/index and beat-counter fields.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_MAX_BURST = 8;

  // Index/tag width for a given requester count (never below one bit).
  function automatic int tag_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  // Beat counter width; one spare bit so MAX_BURST itself is representable.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_pick.sv
// rr_pick
//   Combinational rotating priority encoder. Returns the first asserted
//   request found scanning ptr, ptr+1, ... with wrap modulo NUM_REQ.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this cycle (must be < NUM_REQ)
//   found : at least one request is asserted
//   idx   : winning index (0 when nothing is found)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TAG_W   = tag_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic               found,
  output logic [TAG_W-1:0]   idx
);

  // Walk offsets from the far end back toward ptr so the nearest hit wins.
  always_comb begin
    int cand;
    logic [TAG_W-1:0] cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = TAG_W'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//   Shares one synchronous FIFO write port among NUM_REQ producers. A
//   requester is granted the port for a whole burst, ending on req_last or
//   after MAX_BURST beats, then the grant rotates round-robin. The write
//   path is purely combinational from req_valid/fifo_full/owner.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-requester word present
//   req_last      : per-requester word is last of its burst
//   req_data      : flattened words, requester i at [i*WIDTH +: WIDTH]
//   req_ready     : per-requester accept (only the owner, only when not full)
//   fifo_full     : FIFO full flag
//   fifo_w_en     : FIFO write enable
//   fifo_datain   : FIFO write data (0 when not writing)
//   fifo_tag      : source index of the current write (0 when not writing)
//   busy          : a grant is held
//   grant_id      : current / most recent owner
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int TAG_W     = tag_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_datain,
  output logic [TAG_W-1:0]         fifo_tag,
  output logic                     busy,
  output logic [TAG_W-1:0]         grant_id
);

  localparam int               CNT_W     = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [TAG_W-1:0] TOP_IDX   = TAG_W'(NUM_REQ - 1);

  arb_state_e        state, state_nxt;
  logic [TAG_W-1:0]  owner, owner_nxt;
  logic [TAG_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

  logic              pick_found;
  logic [TAG_W-1:0]  pick_idx;

  logic              own_valid;
  logic              own_last;
  logic [WIDTH-1:0]  own_data;
  logic              beat;
  logic              release_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner-side view of the request bus.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == TAG_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // rst gates the beat so a reset asserted mid-burst never writes.
  assign beat          = (state == ST_BURST) && own_valid && !fifo_full && !rst;
  assign release_grant = beat && (own_last || (beat_cnt == LAST_BEAT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt    = ST_BURST;
          owner_nxt    = pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      ST_BURST: begin
        if (beat) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (release_grant) begin
            state_nxt  = ST_IDLE;
            rr_ptr_nxt = (owner == TOP_IDX) ? '0 : owner + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready   = '0;
    fifo_w_en   = beat;
    fifo_datain = '0;
    fifo_tag    = '0;
    if ((state == ST_BURST) && !fifo_full && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (owner == TAG_W'(i));
      end
    end
    if (beat) begin
      fifo_datain = own_data;
      fifo_tag    = owner;
    end
    busy     = (state == ST_BURST) && !rst;
    grant_id = rst ? '0 : owner;
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter
//   Scoreboard bench for fifo_rr_arbiter (NUM_REQ=4, WIDTH=16, MAX_BURST=8).
//   Producers are modelled as per-requester word queues; every word that
//   should reach the FIFO is pushed, in hand-computed order, onto exp_q and
//   a monitor pops/compares on each fifo_w_en.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 16;
  localparam int MAX_BURST = 8;
  localparam int TAG_W     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_w_en;
  logic [WIDTH-1:0]         fifo_datain;
  logic [TAG_W-1:0]         fifo_tag;
  logic                     busy;
  logic [TAG_W-1:0]         grant_id;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH:0]         src_q [NUM_REQ][$];
  logic [TAG_W+WIDTH-1:0] exp_q [$];
  logic [NUM_REQ-1:0]     acc = '0;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_datain (fifo_datain),
    .fifo_tag    (fifo_tag),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: handshake capture and scoreboard compare on the falling edge.
  initial begin
    logic [TAG_W+WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (fifo_w_en === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got tag %0d data 0x%0h, required no write",
                   fifo_tag, fifo_datain);
        end else begin
          e = exp_q.pop_front();
          if ({fifo_tag, fifo_datain} !== e) begin
            n_err++;
            $display("FAIL fifo_write: got tag %0d data 0x%0h, required tag %0d data 0x%0h",
                     fifo_tag, fifo_datain, e[TAG_W+WIDTH-1:WIDTH], e[WIDTH-1:0]);
          end
        end
      end else begin
        n_cmp++;
        if (fifo_datain !== '0 || fifo_tag !== '0 || fifo_w_en !== 1'b0) begin
          n_err++;
          $display("FAIL idle_outputs: got w_en %b tag %0d data 0x%0h, required 0/0/0",
                   fifo_w_en, fifo_tag, fifo_datain);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic src(input int i, input bit last, input int d);
    src_q[i].push_back({last, WIDTH'(d)});
  endtask

  task automatic expw(input int t, input int d);
    exp_q.push_back({TAG_W'(t), WIDTH'(d)});
  endtask

  task automatic drive();
    logic [WIDTH:0] h;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]                = 1'b1;
        req_last[i]                 = h[WIDTH];
        req_data[i*WIDTH +: WIDTH]  = h[WIDTH-1:0];
      end else begin
        req_valid[i]                = 1'b0;
        req_last[i]                 = 1'b0;
        req_data[i*WIDTH +: WIDTH]  = '0;
      end
    end
  endtask

  // Advance one cycle: retire words accepted last cycle, present the next.
  task automatic adv();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic obs(input string name, input bit b, input int g);
    @(negedge clk);
    chk({name, "_busy"}, 32'(busy), 32'(b));
    if (b) chk({name, "_grant"}, 32'(grant_id), g);
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    adv();
    adv();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      adv();
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;

    // ---- reset state ----
    adv();
    adv();
    @(negedge clk);
    chk("rst_w_en",   32'(fifo_w_en),   0);
    chk("rst_ready",  32'(req_ready),   0);
    chk("rst_data",   32'(fifo_datain), 0);
    chk("rst_tag",    32'(fifo_tag),    0);
    chk("rst_busy",   32'(busy),        0);
    chk("rst_grant",  32'(grant_id),    0);
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy",  32'(busy),      0);
    chk("post_rst_ready", 32'(req_ready), 0);
    chk("post_rst_grant", 32'(grant_id),  0);

    // ---- single requester 2, three words ----
    src(2, 0, 'h11); src(2, 0, 'h22); src(2, 1, 'h33);
    expw(2, 'h11); expw(2, 'h22); expw(2, 'h33);
    adv();
    @(negedge clk);
    chk("t1_arb_busy", 32'(busy),      0);
    chk("t1_arb_wen",  32'(fifo_w_en), 0);
    adv();
    @(negedge clk);
    chk("t1_first_busy",  32'(busy),      1);
    chk("t1_first_grant", 32'(grant_id),  2);
    chk("t1_first_ready", 32'(req_ready), 32'h4);
    chk("t1_first_wen",   32'(fifo_w_en), 1);
    adv(); obs("t1_b2", 1, 2);
    adv(); obs("t1_b3", 1, 2);
    adv(); obs("t1_done", 0, 0);
    chk("t1_hold_grant", 32'(grant_id), 2);
    chk("t1_written", 32'(exp_q.size()), 0);
    // rr_ptr is now 3: with 0 and 3 both waiting, 3 wins first.
    src(0, 1, 'hA0); src(3, 1, 'hB3);
    expw(3, 'hB3); expw(0, 'hA0);
    adv(); obs("t1_rr_c0", 0, 0);
    adv(); obs("t1_rr_c1", 1, 3);
    adv(); obs("t1_rr_c2", 0, 0);
    adv(); obs("t1_rr_c3", 1, 0);
    adv(); obs("t1_rr_c4", 0, 0);
    wait_drain("t1", 20);

    // ---- all four requesting, 2-beat bursts ----
    reset_seq();
    src(0, 0, 'h0A00); src(0, 1, 'h0A01); src(0, 0, 'h0A02); src(0, 1, 'h0A03);
    for (int i = 1; i < NUM_REQ; i++) begin
      src(i, 0, 'h0A00 + 16*i); src(i, 1, 'h0A01 + 16*i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      expw(i, 'h0A00 + 16*i); expw(i, 'h0A01 + 16*i);
    end
    expw(0, 'h0A02); expw(0, 'h0A03);
    for (int k = 0; k < 15; k++) begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      adv();
      obs($sformatf("t2_c%0d", k), (k % 3) != 0, order[k/3]);
    end
    wait_drain("t2", 20);

    // ---- forced release at MAX_BURST ----
    reset_seq();
    for (int j = 0; j < 20; j++) src(1, 0, 'h1100 + j);
    src(3, 1, 'h3300);
    for (int j = 0; j < 8; j++) expw(1, 'h1100 + j);
    expw(3, 'h3300);
    for (int j = 8; j < 20; j++) expw(1, 'h1100 + j);
    for (int k = 0; k < 27; k++) begin
      adv();
      obs($sformatf("t3_c%0d", k), !(k == 0 || k == 9 || k == 11 || k == 20),
          (k == 10) ? 3 : 1);
    end
    chk("t3_hold_ready", 32'(req_ready), 32'h2);
    wait_drain("t3", 5);

    // ---- backpressure: fifo_full for 4 cycles mid-burst ----
    reset_seq();
    for (int j = 0; j < 5; j++) begin
      src(0, j == 4, 'h4400 + j);
      expw(0, 'h4400 + j);
    end
    adv(); obs("t4_c0", 0, 0);
    adv(); obs("t4_c1", 1, 0);
    adv(); obs("t4_c2", 1, 0);
    adv();
    fifo_full = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("t4_stall%0d_wen", s),   32'(fifo_w_en), 0);
      chk($sformatf("t4_stall%0d_ready", s), 32'(req_ready), 0);
      chk($sformatf("t4_stall%0d_busy", s),  32'(busy),      1);
      adv();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("t4_resume_wen",   32'(fifo_w_en), 1);
    chk("t4_resume_ready", 32'(req_ready), 32'h1);
    wait_drain("t4", 20);

    // ---- reset mid-burst (owner 2, beat 3) ----
    reset_seq();
    for (int j = 0; j < 6; j++) src(2, j == 5, 'h5500 + j);
    expw(2, 'h5500); expw(2, 'h5501); expw(2, 'h5502);
    expw(1, 'h5100);
    expw(2, 'h5503); expw(2, 'h5504); expw(2, 'h5505);
    expw(3, 'h5300);
    adv(); obs("t5_c0", 0, 0);
    adv(); obs("t5_c1", 1, 2);
    adv(); obs("t5_c2", 1, 2);
    adv(); obs("t5_c3", 1, 2);
    adv();
    rst = 1'b1;
    src(1, 1, 'h5100);
    src(3, 1, 'h5300);
    drive();
    @(negedge clk);
    chk("t5_rst_wen",   32'(fifo_w_en), 0);
    chk("t5_rst_ready", 32'(req_ready), 0);
    chk("t5_rst_busy",  32'(busy),      0);
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_busy",  32'(busy),      0);
    chk("t5_after_grant", 32'(grant_id),  0);
    chk("t5_after_wen",   32'(fifo_w_en), 0);
    adv(); obs("t5_regrant", 1, 1);
    adv(); obs("t5_gap", 0, 0);
    adv(); obs("t5_resume", 1, 2);
    wait_drain("t5", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
